// File: rtl/huffman_bitpack.sv
// Huffman bit packer: latches a 6-entry code table, packs codes MSB-first into bytes.
// Optional HBP_BITCNT_EN adds a saturating encoded-bit counter on bit_count.
module huffman_bitpack #(
  parameter int CODE_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              code_valid,
  input  logic [CODE_W-1:0] HC1,
  input  logic [CODE_W-1:0] HC2,
  input  logic [CODE_W-1:0] HC3,
  input  logic [CODE_W-1:0] HC4,
  input  logic [CODE_W-1:0] HC5,
  input  logic [CODE_W-1:0] HC6,
  input  logic [CODE_W-1:0] M1,
  input  logic [CODE_W-1:0] M2,
  input  logic [CODE_W-1:0] M3,
  input  logic [CODE_W-1:0] M4,
  input  logic [CODE_W-1:0] M5,
  input  logic [CODE_W-1:0] M6,
  input  logic              sym_valid,
  input  logic [7:0]        sym_data,
  output logic              sym_ready,
  input  logic              flush,
  output logic              out_valid,
  output logic [7:0]        out_data,
  input  logic              out_ready,
  output logic              done,
  output logic              bad_sym
`ifdef HBP_BITCNT_EN
  ,
  output logic [15:0]       bit_count
`endif
);

  localparam int LEN_W = $clog2(CODE_W + 1);
  localparam int CNT_W = $clog2(ACC_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  state_t state, state_n;

  logic [CODE_W-1:0] hc_q  [6];
  logic [LEN_W-1:0]  len_q [6];
  logic [CODE_W-1:0] hc_in [6];
  logic [CODE_W-1:0] m_in  [6];

  logic [ACC_W-1:0]  acc, acc_s, acc_n, ins;
  logic [CNT_W-1:0]  cnt, cnt_s, cnt_n;
  logic [CODE_W-1:0] sel_code, code_m;
  logic [LEN_W-1:0]  sel_len, app_len;
  logic              accept, app, bad_n;
  logic              free, emit, done_n;

  function automatic logic [LEN_W-1:0] mlen(
    input logic [CODE_W-1:0] m
  );
    mlen = '0;
    for (int i = 0; i < CODE_W; i++)
      if (m[i]) mlen = LEN_W'(i + 1);
  endfunction

  always_comb begin
    hc_in[0] = HC1;
    hc_in[1] = HC2;
    hc_in[2] = HC3;
    hc_in[3] = HC4;
    hc_in[4] = HC5;
    hc_in[5] = HC6;
    m_in[0]  = M1;
    m_in[1]  = M2;
    m_in[2]  = M3;
    m_in[3]  = M4;
    m_in[4]  = M5;
    m_in[5]  = M6;
  end

  // Illegal symbols fall through with length 0 and are dropped
  always_comb begin
    sel_code = '0;
    sel_len  = '0;
    for (int k = 0; k < 6; k++) begin
      if (sym_data == 8'(k + 1)) begin
        sel_code = hc_q[k];
        sel_len  = len_q[k];
      end
    end
  end

  assign sym_ready = (state == RUN) &&
                     (cnt <= CNT_W'(ACC_W - CODE_W));
  assign accept  = sym_valid && sym_ready;
  assign app     = accept && (sel_len != '0);
  assign bad_n   = accept && (sel_len == '0);
  assign app_len = app ? sel_len : '0;

  assign free = !out_valid || out_ready;
  assign emit = free &&
                ((cnt >= CNT_W'(8)) ||
                 ((state == FLUSH) && (cnt != '0)));

  // Bits stay MSB-aligned in acc; bits below cnt are always zero,
  // so a padded byte is just the top 8 bits.
  always_comb begin
    acc_s  = emit ? (acc << 8) : acc;
    cnt_s  = cnt;
    if (emit)
      cnt_s = (cnt >= CNT_W'(8)) ? cnt - CNT_W'(8) : '0;
    code_m = sel_code & ~({CODE_W{1'b1}} << sel_len);
    ins    = {code_m, {(ACC_W - CODE_W){1'b0}}};
    ins    = ins << (LEN_W'(CODE_W) - sel_len);
    ins    = ins >> cnt_s;
    acc_n  = app ? (acc_s | ins) : acc_s;
    cnt_n  = cnt_s + CNT_W'(app_len);
  end

  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    unique case (state)
      IDLE:  if (code_valid) state_n = RUN;
      RUN:   if (flush) state_n = FLUSH;
      FLUSH: begin
        if ((cnt == '0) && !out_valid) begin
          done_n  = 1'b1;
          state_n = RUN;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
      bad_sym   <= 1'b0;
      for (int k = 0; k < 6; k++) begin
        hc_q[k]  <= '0;
        len_q[k] <= '0;
      end
    end else begin
      state   <= state_n;
      acc     <= acc_n;
      cnt     <= cnt_n;
      done    <= done_n;
      bad_sym <= bad_n;
      if (emit) begin
        out_data  <= acc[ACC_W-1 -: 8];
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (code_valid) begin
        for (int k = 0; k < 6; k++) begin
          hc_q[k]  <= hc_in[k];
          len_q[k] <= mlen(m_in[k]);
        end
      end
    end
  end

`ifdef HBP_BITCNT_EN
  logic [16:0] bc_sum;

  assign bc_sum = {1'b0, bit_count} + 17'(app_len);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      bit_count <= '0;
    else if (done)
      bit_count <= 16'(app_len);
    else if (bc_sum[16])
      bit_count <= 16'hFFFF;
    else
      bit_count <= bc_sum[15:0];
  end
`endif

endmodule
